pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the processor datapath. It holds the architectural PC and computes the next fetch address each cycle. It sits directly downstream of the word-offset shifter and consumes that shifter's output (sign-extended immediate << 2) as the branch displacement. It adds a run/halt state machine, stall hold, and a retired-instruction counter for the bench and debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  leaves IDLE and begins fetching.
- stall  input  1  holds PC and counter for this cycle.
- branch_taken  input  1  branch resolved taken in the current cycle.
- shifted_offset  input  32  branch displacement, already shifted left 2.
- jump  input  1  J-type jump in the current cycle.
- jump_index  input  26  instruction[25:0] of the jump.
- halt  input  1  halt instruction decoded in the current cycle.
- pc  output  32  current fetch address (registered).
- pc_plus_4  output  32  pc + 4 (combinational).
- running  output  1  high in RUN (registered state decode).
- halted  output  1  high in HALTED.
- retired_count  output  COUNT_W  instructions retired since reset.

Fixed: one clock; reset is synchronous and active-high.

## Operation
- States: IDLE, RUN, HALTED. Reset forces IDLE.
- IDLE: pc = RESET_PC, frozen, and all control inputs are ignored except start. start=1 moves the block to RUN on the next edge. pc is unchanged by this transition, so the first fetch is RESET_PC.
- RUN, no stall: next pc is chosen in this priority order:
  - halt → pc unchanged; state → HALTED.
  - jump → {pc_plus_4[31:28], jump_index, 2'b00}.
  - branch_taken → pc_plus_4 + shifted_offset.
  - otherwise → pc_plus_4.
- RUN with stall=1: pc, state and retired_count all hold. branch_taken, jump and halt are ignored that cycle, because upstream re-presents them. halt does not override stall.
- HALTED: everything is frozen until reset. start is ignored.
- retired_count increments by 1 on each RUN cycle with stall=0, including the cycle that asserts halt. It wraps modulo 2^COUNT_W.
- Arithmetic: all adds are 32-bit modulo 2^32 and wrap silently. Backward branches are two's complement.
- The next pc is always forced to bits [1:0] = 2'b00. Any nonzero low bits of shifted_offset are dropped.
- jump and branch_taken together: jump wins. jump, branch_taken and halt together: halt wins.

## Timing
- Reset values: pc = RESET_PC, running = 0, halted = 0, retired_count = 0, state = IDLE.
- Next-pc selection is combinational from the current-cycle inputs. pc updates on the following rising edge, giving a 1-cycle latency from control input to new pc.
- pc_plus_4 tracks pc combinationally with 0 latency.
- running and halted change on the same edge as the state register.
- Reset asserted mid-RUN or in HALTED: on the next edge the block returns to the reset values, overriding all other inputs.

## Structure
- Shared package pc_seq_pkg holds:
  - state enum {IDLE, RUN, HALTED};
  - PC_INC = 32'd4;
  - PC_W = 32.
- One sub-module: branch_target_adder, a 32-bit combinational adder computing pc_plus_4 + shifted_offset. The same adder type is reused for pc + PC_INC.
- The top level contains the state register, pc register, next-pc mux and counter.

## Test plan
- Reset then start, 3 cycles with no control inputs:
  - pc goes 0x0, 0x4, 0x8, 0xC;
  - retired_count = 3;
  - running = 1 from the edge after start.
- At pc=0x100, branch_taken=1 with shifted_offset=0xFFFF_FFF0: next pc = 0xF4. With shifted_offset=0x40: next pc = 0x144.
- At pc=0x1000_0010, jump=1 with jump_index=0x000_0040 and branch_taken=1 at the same time: next pc = 0x1000_0100 (jump wins).
- stall=1 for 2 cycles at pc=0x20, with branch_taken=1 and halt=1 asserted:
  - pc stays 0x20;
  - retired_count unchanged;
  - state stays RUN.
- After stall is released, halt=1 at pc=0x24:
  - pc stays 0x24;
  - halted = 1;
  - retired_count increments once;
  - later start and jump pulses cause no change.
- Overflow cases:
  - pc=0xFFFF_FFFC with no control input → next pc = 0x0;
  - reset asserted while RUN at pc=0x80 → next edge gives pc = RESET_PC, state IDLE, counter 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    localparam int          PC_W   = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Fetch addresses are word aligned; clear the byte-offset bits.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Combinational modulo-2^W adder, used both for pc + 4 and for the
// branch target pc_plus_4 + displacement.
module branch_target_adder
    import pc_seq_pkg::*;
#(
    parameter int W = PC_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    // Carry out is discarded so the result wraps silently.
    always_comb begin
        sum = a + b;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run/halt state machine, stall hold, next-pc
// selection (halt > jump > branch > sequential) and retired-instruction counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        shifted_offset,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    input  logic               halt,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus_4,
    output logic               running,
    output logic               halted,
    output logic [COUNT_W-1:0] retired_count
);

    state_t               state_q;
    state_t               state_n;
    logic [PC_W-1:0]      pc_q;
    logic [PC_W-1:0]      pc_n;
    logic [PC_W-1:0]      branch_target;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   count_n;

    branch_target_adder #(.W(PC_W)) u_inc_adder (
        .a   (pc_q),
        .b   (PC_INC),
        .sum (pc_plus_4)
    );

    branch_target_adder #(.W(PC_W)) u_branch_adder (
        .a   (pc_plus_4),
        .b   (shifted_offset),
        .sum (branch_target)
    );

    // Next-state, next-pc and counter selection from the current-cycle inputs.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        count_n = count_q;
        case (state_q)
            IDLE: begin
                // Only start is honoured; pc stays at RESET_PC so the first
                // fetch after start is RESET_PC itself.
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                // A stalled cycle ignores control inputs; upstream re-presents them.
                if (!stall) begin
                    count_n = count_q + 1'b1;
                    if (halt) begin
                        state_n = HALTED;
                    end else if (jump) begin
                        pc_n = {pc_plus_4[31:28], jump_index, 2'b00};
                    end else if (branch_taken) begin
                        pc_n = branch_target;
                    end else begin
                        pc_n = pc_plus_4;
                    end
                end
            end
            default: begin
                // HALTED: frozen until reset.
            end
        endcase
        pc_n = word_align(pc_n);
    end

    // State, pc and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            count_q <= count_n;
        end
    end

    assign pc            = pc_q;
    assign running       = (state_q == RUN);
    assign halted        = (state_q == HALTED);
    assign retired_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] shifted_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        running;
    logic        halted;
    logic [31:0] retired_count;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .shifted_offset (shifted_offset),
        .jump           (jump),
        .jump_index     (jump_index),
        .halt           (halt),
        .pc             (pc),
        .pc_plus_4      (pc_plus_4),
        .running        (running),
        .halted         (halted),
        .retired_count  (retired_count)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        reset = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        shifted_offset = 32'h0; jump = 1'b0; jump_index = 26'h0; halt = 1'b0;
    endtask

    // One rising edge, then settle 1 time unit past it before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        n_cmp++; if (pc_plus_4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 got %h want %h", pc_plus_4, 32'h4); end
        n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_cmp++; if (retired_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", retired_count); end
        // IDLE ignores everything except start.
        jump = 1'b1; jump_index = 26'h40; halt = 1'b1; branch_taken = 1'b1; shifted_offset = 32'h100;
        cyc();
        clear_inputs();
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL idle_hold_pc got %h want %h", pc, 32'h0); end
        n_cmp++; if (running !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL idle_hold_state got run=%b halt=%b want 0/0", running, halted); end
    endtask

    task automatic test_sequential();
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_cmp++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running got %b want 1", running); end
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL start_pc got %h want %h", pc, 32'h0); end
        n_cmp++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL start_count got %0d want 0", retired_count); end
        cyc();
        n_cmp++; if (pc !== 32'h4) begin n_fail++; $display("FAIL seq_pc1 got %h want %h", pc, 32'h4); end
        cyc();
        n_cmp++; if (pc !== 32'h8) begin n_fail++; $display("FAIL seq_pc2 got %h want %h", pc, 32'h8); end
        cyc();
        n_cmp++; if (pc !== 32'hC) begin n_fail++; $display("FAIL seq_pc3 got %h want %h", pc, 32'hC); end
        n_cmp++; if (pc_plus_4 !== 32'h10) begin n_fail++; $display("FAIL seq_pc4 got %h want %h", pc_plus_4, 32'h10); end
        n_cmp++; if (retired_count !== 32'd3) begin n_fail++; $display("FAIL seq_count got %0d want 3", retired_count); end
    endtask

    task automatic test_branch();
        // 0xC: jump to {0, 0x40, 00} = 0x100
        jump = 1'b1; jump_index = 26'h40;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL jump_0x100 got %h want %h", pc, 32'h100); end
        // backward: 0x104 - 0x10 = 0xF4
        branch_taken = 1'b1; shifted_offset = 32'hFFFF_FFF0;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'hF4) begin n_fail++; $display("FAIL branch_back got %h want %h", pc, 32'hF4); end
        jump = 1'b1; jump_index = 26'h40;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL jump_again got %h want %h", pc, 32'h100); end
        // forward: 0x104 + 0x40 = 0x144
        branch_taken = 1'b1; shifted_offset = 32'h40;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h144) begin n_fail++; $display("FAIL branch_fwd got %h want %h", pc, 32'h144); end
        // low offset bits dropped: 0x148 + 0x43 = 0x18B -> 0x188
        branch_taken = 1'b1; shifted_offset = 32'h43;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h188) begin n_fail++; $display("FAIL branch_align got %h want %h", pc, 32'h188); end
        n_cmp++; if (retired_count !== 32'd8) begin n_fail++; $display("FAIL branch_count got %0d want 8", retired_count); end
    endtask

    task automatic test_jump_priority();
        // 0x18C + 0x0FFF_FE84 = 0x1000_0010
        branch_taken = 1'b1; shifted_offset = 32'h0FFF_FE84;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h1000_0010) begin n_fail++; $display("FAIL branch_far got %h want %h", pc, 32'h1000_0010); end
        jump = 1'b1; jump_index = 26'h40; branch_taken = 1'b1; shifted_offset = 32'h100;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h1000_0100) begin n_fail++; $display("FAIL jump_wins got %h want %h", pc, 32'h1000_0100); end
    endtask

    task automatic test_wrap();
        // 0x1000_0104 + 0xEFFF_FEF8 = 0xFFFF_FFFC
        branch_taken = 1'b1; shifted_offset = 32'hEFFF_FEF8;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup got %h want %h", pc, 32'hFFFF_FFFC); end
        n_cmp++; if (pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h want %h", pc_plus_4, 32'h0); end
        cyc();
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want %h", pc, 32'h0); end
        n_cmp++; if (retired_count !== 32'd12) begin n_fail++; $display("FAIL wrap_count got %0d want 12", retired_count); end
    endtask

    task automatic test_stall_halt();
        jump = 1'b1; jump_index = 26'h8;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h20) begin n_fail++; $display("FAIL stall_setup got %h want %h", pc, 32'h20); end
        for (int i = 0; i < 2; i++) begin
            stall = 1'b1; branch_taken = 1'b1; shifted_offset = 32'h40; halt = 1'b1;
            cyc();
            n_cmp++; if (pc !== 32'h20) begin n_fail++; $display("FAIL stall_pc%0d got %h want %h", i, pc, 32'h20); end
            n_cmp++; if (retired_count !== 32'd13) begin n_fail++; $display("FAIL stall_count%0d got %0d want 13", i, retired_count); end
            n_cmp++; if (running !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL stall_state%0d got run=%b halt=%b want 1/0", i, running, halted); end
        end
        clear_inputs();
        cyc();
        n_cmp++; if (pc !== 32'h24) begin n_fail++; $display("FAIL unstall_pc got %h want %h", pc, 32'h24); end
        halt = 1'b1;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h24) begin n_fail++; $display("FAIL halt_pc got %h want %h", pc, 32'h24); end
        n_cmp++; if (halted !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL halt_state got run=%b halt=%b want 0/1", running, halted); end
        n_cmp++; if (retired_count !== 32'd15) begin n_fail++; $display("FAIL halt_count got %0d want 15", retired_count); end
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; jump = 1'b1; jump_index = 26'h40; branch_taken = 1'b1; shifted_offset = 32'h40;
            cyc();
        end
        clear_inputs();
        n_cmp++; if (pc !== 32'h24) begin n_fail++; $display("FAIL halted_frozen_pc got %h want %h", pc, 32'h24); end
        n_cmp++; if (halted !== 1'b1 || retired_count !== 32'd15) begin n_fail++; $display("FAIL halted_frozen got halt=%b cnt=%0d want 1/15", halted, retired_count); end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1; start = 1'b1;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h0 || halted !== 1'b0 || running !== 1'b0 || retired_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_from_halt got pc=%h run=%b halt=%b cnt=%0d want 0/0/0/0", pc, running, halted, retired_count); end
        start = 1'b1;
        cyc(); clear_inputs();
        jump = 1'b1; jump_index = 26'h20;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h80 || retired_count !== 32'd1) begin n_fail++; $display("FAIL run_0x80 got pc=%h cnt=%0d want 80/1", pc, retired_count); end
        reset = 1'b1; jump = 1'b1; jump_index = 26'h40; start = 1'b1;
        cyc(); clear_inputs();
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_run_pc got %h want %h", pc, 32'h0); end
        n_cmp++; if (running !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_run_state got run=%b halt=%b want 0/0", running, halted); end
        n_cmp++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_run_count got %0d want 0", retired_count); end
    endtask

    initial begin
        clear_inputs();
        #2;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_wrap();
        test_stall_halt();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
